// File: rtl/instr_encoder_if.sv
// Request and IR-bus handshake bundle for instr_encoder.
// master = requester/consumer side, slave = the encoder itself.
interface instr_encoder_if;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_cmd;
  logic [5:0] req_imm;
  logic       req_dst;
  logic       req_src;
  logic [7:0] ir;
  logic       ir_valid;
  logic       ir_ready;

  modport master (
    output req_valid, req_cmd, req_imm, req_dst, req_src, ir_ready,
    input  req_ready, ir, ir_valid
  );

  modport slave (
    input  req_valid, req_cmd, req_imm, req_dst, req_src, ir_ready,
    output req_ready, ir, ir_valid
  );
endinterface

// File: rtl/instr_encoder.sv
// Instruction issue front-end: encodes symbolic requests to ISA bytes, queues them, issues on IR.
// Optional macro INSTR_ENC_COUNT_EN adds a 16-bit issue counter output (issue_cnt).
module instr_encoder #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             clr_n,
  instr_encoder_if.slave   bus,
  input  logic             resume,
  output logic             err,
  output logic             halted,
`ifdef INSTR_ENC_COUNT_EN
  output logic [15:0]      issue_cnt,
`endif
  output logic [1:0]       state_dbg
);

  // Handshakes: a request transfers on a rising edge where req_valid && req_ready;
  // the head entry on ir is consumed on a rising edge where ir_valid && ir_ready.

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [7:0]     OP_HALT  = 8'hFF;
  localparam logic [7:0]     OP_NOP   = 8'hC0;

  state_t           state, state_nx;
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nx;
  logic [PTR_W:0]   count, count_nx;
  logic [7:0]       enc, head_nx;
  logic             legal, accept, push, pop, valid_nx;

  always_comb begin
    enc   = OP_NOP;
    legal = 1'b1;
    case (bus.req_cmd)
      3'd0:    enc = {2'b00, bus.req_imm};
      3'd1:    enc = {2'b01, bus.req_imm};
      3'd2:    enc = {3'b100, bus.req_dst, 1'b0, bus.req_src, 2'b00};
      3'd3:    enc = OP_HALT;
      3'd4:    enc = OP_NOP;
      default: legal = 1'b0;
    endcase
  end

  assign accept = bus.req_valid && bus.req_ready;
  assign push   = accept && legal;
  assign pop    = bus.ir_valid && bus.ir_ready;

  always_comb begin
    count_nx  = count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    rd_ptr_nx = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    state_nx  = state;
    case (state)
      RUN:     if (push && enc == OP_HALT) state_nx = DRAIN;
      DRAIN:   if (pop && bus.ir == OP_HALT) state_nx = HALTED;
      HALTED:  if (resume) state_nx = RUN;
      default: state_nx = RUN;
    endcase
    // A byte pushed into the slot that becomes head this edge is not in mem yet.
    head_nx  = (push && rd_ptr_nx == wr_ptr) ? enc : mem[rd_ptr_nx];
    valid_nx = (count_nx != '0) && (state_nx != HALTED);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state         <= RUN;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      err           <= 1'b0;
      bus.req_ready <= 1'b0;
      bus.ir_valid  <= 1'b0;
      bus.ir        <= OP_NOP;
    end else begin
      state         <= state_nx;
      count         <= count_nx;
      rd_ptr        <= rd_ptr_nx;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      err           <= accept && !legal;
      bus.req_ready <= (state_nx == RUN) && (count_nx != FULL_CNT);
      bus.ir_valid  <= valid_nx;
      bus.ir        <= valid_nx ? head_nx : OP_NOP;
    end
  end

`ifdef INSTR_ENC_COUNT_EN
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)   issue_cnt <= 16'd0;
    else if (pop) issue_cnt <= issue_cnt + 16'd1;
  end
`endif

  assign halted    = (state == HALTED);
  assign state_dbg = state;

endmodule
